traffic_phase_scheduler: RTL and testbench

- Timed phase sequencer for a two-way intersection: main street north-south (NS) and side street east-west (EW).
- Drives the 6-bit `lights` bus consumed by the intersection lamp drivers.
- NS green is the rest state. EW green is served only on a vehicle request (`ew_req`) or a pedestrian request (`ped_req`). Both requests are latched until served.
- Yellow and all-red clearance intervals come from parameters.

---
 rtl/traffic_pkg.sv | 54 +++++
 rtl/phase_timer.sv | 38 +++
 rtl/traffic_phase_scheduler.sv | 110 +++++++++++
 tb/tb_traffic_phase_scheduler.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic phase scheduler: state encodings,
// lamp bit positions and the lamp pattern shown in each state.
package traffic_pkg;

  // 3-bit state encodings (also driven out on the phase status port)
  localparam logic [2:0] ST_NS_GRN = 3'd0;
  localparam logic [2:0] ST_NS_YEL = 3'd1;
  localparam logic [2:0] ST_AR1    = 3'd2;
  localparam logic [2:0] ST_EW_GRN = 3'd3;
  localparam logic [2:0] ST_EW_YEL = 3'd4;
  localparam logic [2:0] ST_AR2    = 3'd5;

  typedef enum logic [2:0] {
    S_NS_GRN = ST_NS_GRN,
    S_NS_YEL = ST_NS_YEL,
    S_AR1    = ST_AR1,
    S_EW_GRN = ST_EW_GRN,
    S_EW_YEL = ST_EW_YEL,
    S_AR2    = ST_AR2
  } state_e;

  // Bit positions inside the 6-bit lamp bus
  localparam int LT_NS_RED = 5;
  localparam int LT_NS_YEL = 4;
  localparam int LT_NS_GRN = 3;
  localparam int LT_EW_RED = 2;
  localparam int LT_EW_YEL = 1;
  localparam int LT_EW_GRN = 0;

  // Lamp patterns, exactly one lamp lit per street
  localparam logic [5:0] LIGHTS_NS_GRN = 6'(1 << LT_NS_GRN) | 6'(1 << LT_EW_RED);
  localparam logic [5:0] LIGHTS_NS_YEL = 6'(1 << LT_NS_YEL) | 6'(1 << LT_EW_RED);
  localparam logic [5:0] LIGHTS_AR1    = 6'(1 << LT_NS_RED) | 6'(1 << LT_EW_RED);
  localparam logic [5:0] LIGHTS_EW_GRN = 6'(1 << LT_NS_RED) | 6'(1 << LT_EW_GRN);
  localparam logic [5:0] LIGHTS_EW_YEL = 6'(1 << LT_NS_RED) | 6'(1 << LT_EW_YEL);
  localparam logic [5:0] LIGHTS_AR2    = 6'(1 << LT_NS_RED) | 6'(1 << LT_EW_RED);

  // Pure decode of a state into its lamp pattern; anything unknown shows all-red
  function automatic logic [5:0] lights_of(input state_e s);
    logic [5:0] l;
    l = LIGHTS_AR2;
    case (s)
      S_NS_GRN: l = LIGHTS_NS_GRN;
      S_NS_YEL: l = LIGHTS_NS_YEL;
      S_AR1:    l = LIGHTS_AR1;
      S_EW_GRN: l = LIGHTS_EW_GRN;
      S_EW_YEL: l = LIGHTS_EW_YEL;
      S_AR2:    l = LIGHTS_AR2;
      default:  l = LIGHTS_AR2;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that saturates at zero; zero_o marks the last
// cycle of the current phase.
module phase_timer #(
  parameter int unsigned      CNT_W   = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Load takes priority; otherwise count down and hold once at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register with synchronous active-low clear
  always_ff @(posedge clk) begin
    if (!clr) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Two-way intersection phase sequencer. NS green is the rest state; EW is
// served only when a vehicle or pedestrian request has been latched, and
// never before NS has had its minimum green time.
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int unsigned NS_MIN   = 8,
  parameter int unsigned EW_GREEN = 6,
  parameter int unsigned YEL_T    = 3,
  parameter int unsigned ALLRED_T = 2,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       ew_req,
  input  logic       ped_req,
  output logic [5:0] lights,
  output logic       walk,
  output logic [2:0] phase
);

  // Timer reload values: a phase of D cycles starts the counter at D-1
  localparam logic [CNT_W-1:0] NS_MIN_M1 = CNT_W'(NS_MIN - 1);
  localparam logic [CNT_W-1:0] EW_GRN_M1 = CNT_W'(EW_GREEN - 1);
  localparam logic [CNT_W-1:0] YEL_M1    = CNT_W'(YEL_T - 1);
  localparam logic [CNT_W-1:0] AR_M1     = CNT_W'(ALLRED_T - 1);

  state_e           state_q, state_d;
  logic             timer_zero;
  logic             timer_load;
  logic [CNT_W-1:0] timer_load_val;
  logic             any_req;
  logic             enter_ew, leave_ew;
  logic             ew_pend_q, ew_pend_d;
  logic             ped_pend_q, ped_pend_d;
  logic             walk_act_q, walk_act_d;

  // Next-state logic: every phase runs its timer out; NS green also needs demand
  always_comb begin
    state_d = state_q;
    any_req = ew_pend_q | ped_pend_q | ew_req | ped_req;
    case (state_q)
      S_NS_GRN: if (timer_zero && any_req) state_d = S_NS_YEL;
      S_NS_YEL: if (timer_zero) state_d = S_AR1;
      S_AR1:    if (timer_zero) state_d = S_EW_GRN;
      S_EW_GRN: if (timer_zero) state_d = S_EW_YEL;
      S_EW_YEL: if (timer_zero) state_d = S_AR2;
      S_AR2:    if (timer_zero) state_d = S_NS_GRN;
      default:  state_d = S_AR2;
    endcase
  end

  // Reload the timer with the new phase length whenever the state changes
  always_comb begin
    timer_load     = (state_d != state_q);
    timer_load_val = AR_M1;
    case (state_d)
      S_NS_GRN:          timer_load_val = NS_MIN_M1;
      S_NS_YEL, S_EW_YEL: timer_load_val = YEL_M1;
      S_EW_GRN:          timer_load_val = EW_GRN_M1;
      S_AR1, S_AR2:      timer_load_val = AR_M1;
      default:           timer_load_val = AR_M1;
    endcase
  end

  phase_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (AR_M1)
  ) u_phase_timer (
    .clk        (clk),
    .clr        (clr),
    .load_i     (timer_load),
    .load_val_i (timer_load_val),
    .zero_o     (timer_zero)
  );

  // Request latches clear on EW entry, but a request in that same cycle re-arms them
  always_comb begin
    enter_ew   = (state_q == S_AR1) && (state_d == S_EW_GRN);
    leave_ew   = (state_q == S_EW_GRN) && (state_d != S_EW_GRN);
    ew_pend_d  = enter_ew ? ew_req  : (ew_pend_q  | ew_req);
    ped_pend_d = enter_ew ? ped_req : (ped_pend_q | ped_req);
    walk_act_d = walk_act_q;
    if (enter_ew) begin
      walk_act_d = ped_pend_q | ped_req;
    end else if (leave_ew) begin
      walk_act_d = 1'b0;
    end
  end

  // State and latch registers; clear overrides any transition or request
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q    <= S_AR2;
      ew_pend_q  <= 1'b0;
      ped_pend_q <= 1'b0;
      walk_act_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ew_pend_q  <= ew_pend_d;
      ped_pend_q <= ped_pend_d;
      walk_act_q <= walk_act_d;
    end
  end

  assign lights = lights_of(state_q);
  assign walk   = walk_act_q & (state_q == S_EW_GRN);
  assign phase  = state_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler: a table of per-cycle vectors
// plus hand-written sequences for the multi-cycle corner cases.
module tb_traffic_phase_scheduler;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       ew_req = 1'b0;
  logic       ped_req = 1'b0;
  logic [5:0] lights;
  logic       walk;
  logic [2:0] phase;

  traffic_phase_scheduler dut (
    .clk     (clk),
    .clr     (clr),
    .ew_req  (ew_req),
    .ped_req (ped_req),
    .lights  (lights),
    .walk    (walk),
    .phase   (phase)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] L_NSG = 6'b001100;
  localparam logic [5:0] L_NSY = 6'b010100;
  localparam logic [5:0] L_AR  = 6'b100100;
  localparam logic [5:0] L_EWG = 6'b100001;
  localparam logic [5:0] L_EWY = 6'b100010;

  localparam logic [2:0] P_NSG = 3'd0;
  localparam logic [2:0] P_NSY = 3'd1;
  localparam logic [2:0] P_AR1 = 3'd2;
  localparam logic [2:0] P_EWG = 3'd3;
  localparam logic [2:0] P_EWY = 3'd4;
  localparam logic [2:0] P_AR2 = 3'd5;

  // One record = inputs applied before an edge, outputs required after it
  typedef struct {
    logic       c;
    logic       e;
    logic       p;
    logic [5:0] l;
    logic       w;
    logic [2:0] ph;
    int         sc;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   step_no = 0;

  task automatic add(input int n, input logic c, input logic e, input logic p,
                     input logic [5:0] l, input logic w, input logic [2:0] ph, input int sc);
    vec_t v;
    v.c = c; v.e = e; v.p = p; v.l = l; v.w = w; v.ph = ph; v.sc = sc;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic step(input logic c, input logic e, input logic p,
                      input logic [5:0] l, input logic w, input logic [2:0] ph, input int sc);
    clr = c; ew_req = e; ped_req = p;
    @(posedge clk);
    #1;
    step_no++;
    n_checks++;
    if (lights !== l || walk !== w || phase !== ph) begin
      n_fail++;
      $display("FAIL scen%0d step%0d: got lights=%b walk=%b phase=%0d, expected lights=%b walk=%b phase=%0d",
               sc, step_no, lights, walk, phase, l, w, ph);
    end else begin
      $display("scen%0d step%0d: clr=%b ew=%b ped=%b -> lights=%b walk=%b phase=%0d ok",
               sc, step_no, c, e, p, lights, walk, phase);
    end
  endtask

  task automatic run(input int n, input logic c, input logic e, input logic p,
                     input logic [5:0] l, input logic w, input logic [2:0] ph, input int sc);
    for (int i = 0; i < n; i++) step(c, e, p, l, w, ph, sc);
  endtask

  initial begin
    // Scenario 1: reset, no requests -> NS green held
    add(2,  1'b0, 1'b0, 1'b0, L_AR,  1'b0, P_AR2, 1);
    add(1,  1'b1, 1'b0, 1'b0, L_AR,  1'b0, P_AR2, 1);
    add(50, 1'b1, 1'b0, 1'b0, L_NSG, 1'b0, P_NSG, 1);

    // Scenario 2: ew_req held from reset (reset must ignore it), two full rounds
    add(2, 1'b0, 1'b1, 1'b0, L_AR, 1'b0, P_AR2, 2);
    add(1, 1'b1, 1'b1, 1'b0, L_AR, 1'b0, P_AR2, 2);
    for (int r = 0; r < 2; r++) begin
      add(8, 1'b1, 1'b1, 1'b0, L_NSG, 1'b0, P_NSG, 2);
      add(3, 1'b1, 1'b1, 1'b0, L_NSY, 1'b0, P_NSY, 2);
      add(2, 1'b1, 1'b1, 1'b0, L_AR,  1'b0, P_AR1, 2);
      add(6, 1'b1, 1'b1, 1'b0, L_EWG, 1'b0, P_EWG, 2);
      add(3, 1'b1, 1'b1, 1'b0, L_EWY, 1'b0, P_EWY, 2);
      add(2, 1'b1, 1'b1, 1'b0, L_AR,  1'b0, P_AR2, 2);
    end
    add(8, 1'b1, 1'b1, 1'b0, L_NSG, 1'b0, P_NSG, 2);
    add(1, 1'b1, 1'b1, 1'b0, L_NSY, 1'b0, P_NSY, 2);

    // Scenario 3: one-cycle ew_req early in NS green is latched, served after NS_MIN
    add(2,  1'b0, 1'b0, 1'b0, L_AR,  1'b0, P_AR2, 3);
    add(1,  1'b1, 1'b0, 1'b0, L_AR,  1'b0, P_AR2, 3);
    add(2,  1'b1, 1'b0, 1'b0, L_NSG, 1'b0, P_NSG, 3);
    add(1,  1'b1, 1'b1, 1'b0, L_NSG, 1'b0, P_NSG, 3);
    add(5,  1'b1, 1'b0, 1'b0, L_NSG, 1'b0, P_NSG, 3);
    add(3,  1'b1, 1'b0, 1'b0, L_NSY, 1'b0, P_NSY, 3);
    add(2,  1'b1, 1'b0, 1'b0, L_AR,  1'b0, P_AR1, 3);
    add(6,  1'b1, 1'b0, 1'b0, L_EWG, 1'b0, P_EWG, 3);
    add(3,  1'b1, 1'b0, 1'b0, L_EWY, 1'b0, P_EWY, 3);
    add(2,  1'b1, 1'b0, 1'b0, L_AR,  1'b0, P_AR2, 3);
    add(20, 1'b1, 1'b0, 1'b0, L_NSG, 1'b0, P_NSG, 3);

    // Scenario 4: ew_req pulse in NS green cycle 20 -> yellow on the next edge
    add(2,  1'b0, 1'b0, 1'b0, L_AR,  1'b0, P_AR2, 4);
    add(1,  1'b1, 1'b0, 1'b0, L_AR,  1'b0, P_AR2, 4);
    add(20, 1'b1, 1'b0, 1'b0, L_NSG, 1'b0, P_NSG, 4);
    add(1,  1'b1, 1'b1, 1'b0, L_NSY, 1'b0, P_NSY, 4);
    add(2,  1'b1, 1'b0, 1'b0, L_NSY, 1'b0, P_NSY, 4);
    add(2,  1'b1, 1'b0, 1'b0, L_AR,  1'b0, P_AR1, 4);
    add(6,  1'b1, 1'b0, 1'b0, L_EWG, 1'b0, P_EWG, 4);
    add(3,  1'b1, 1'b0, 1'b0, L_EWY, 1'b0, P_EWY, 4);
    add(2,  1'b1, 1'b0, 1'b0, L_AR,  1'b0, P_AR2, 4);
    add(10, 1'b1, 1'b0, 1'b0, L_NSG, 1'b0, P_NSG, 4);

    foreach (vecs[i]) begin
      step(vecs[i].c, vecs[i].e, vecs[i].p, vecs[i].l, vecs[i].w, vecs[i].ph, vecs[i].sc);
    end

    // Scenario 5: ped pulse in NS green gives walk; a ped pulse on the EW entry
    // edge walks now and also re-arms a second service with walk
    run(2, 1'b0, 1'b0, 1'b0, L_AR,  1'b0, P_AR2, 5);
    run(1, 1'b1, 1'b0, 1'b0, L_AR,  1'b0, P_AR2, 5);
    run(2, 1'b1, 1'b0, 1'b0, L_NSG, 1'b0, P_NSG, 5);
    run(1, 1'b1, 1'b0, 1'b1, L_NSG, 1'b0, P_NSG, 5);
    run(5, 1'b1, 1'b0, 1'b0, L_NSG, 1'b0, P_NSG, 5);
    run(3, 1'b1, 1'b0, 1'b0, L_NSY, 1'b0, P_NSY, 5);
    run(2, 1'b1, 1'b0, 1'b0, L_AR,  1'b0, P_AR1, 5);
    run(1, 1'b1, 1'b0, 1'b1, L_EWG, 1'b1, P_EWG, 5);
    run(5, 1'b1, 1'b0, 1'b0, L_EWG, 1'b1, P_EWG, 5);
    run(3, 1'b1, 1'b0, 1'b0, L_EWY, 1'b0, P_EWY, 5);
    run(2, 1'b1, 1'b0, 1'b0, L_AR,  1'b0, P_AR2, 5);
    run(8, 1'b1, 1'b0, 1'b0, L_NSG, 1'b0, P_NSG, 5);
    run(3, 1'b1, 1'b0, 1'b0, L_NSY, 1'b0, P_NSY, 5);
    run(2, 1'b1, 1'b0, 1'b0, L_AR,  1'b0, P_AR1, 5);
    run(6, 1'b1, 1'b0, 1'b0, L_EWG, 1'b1, P_EWG, 5);
    run(3, 1'b1, 1'b0, 1'b0, L_EWY, 1'b0, P_EWY, 5);
    run(2, 1'b1, 1'b0, 1'b0, L_AR,  1'b0, P_AR2, 5);
    run(15, 1'b1, 1'b0, 1'b0, L_NSG, 1'b0, P_NSG, 5);

    // Scenario 6: reset in EW green cycle 3 with both requests pending wipes them
    run(2, 1'b0, 1'b0, 1'b0, L_AR,  1'b0, P_AR2, 6);
    run(1, 1'b1, 1'b0, 1'b0, L_AR,  1'b0, P_AR2, 6);
    run(2, 1'b1, 1'b0, 1'b0, L_NSG, 1'b0, P_NSG, 6);
    run(1, 1'b1, 1'b1, 1'b0, L_NSG, 1'b0, P_NSG, 6);
    run(5, 1'b1, 1'b0, 1'b0, L_NSG, 1'b0, P_NSG, 6);
    run(3, 1'b1, 1'b0, 1'b0, L_NSY, 1'b0, P_NSY, 6);
    run(2, 1'b1, 1'b0, 1'b0, L_AR,  1'b0, P_AR1, 6);
    run(1, 1'b1, 1'b0, 1'b0, L_EWG, 1'b0, P_EWG, 6);
    run(1, 1'b1, 1'b1, 1'b1, L_EWG, 1'b0, P_EWG, 6);
    run(1, 1'b1, 1'b0, 1'b0, L_EWG, 1'b0, P_EWG, 6);
    run(1, 1'b0, 1'b1, 1'b1, L_AR,  1'b0, P_AR2, 6);
    run(1, 1'b1, 1'b0, 1'b0, L_AR,  1'b0, P_AR2, 6);
    run(30, 1'b1, 1'b0, 1'b0, L_NSG, 1'b0, P_NSG, 6);

    // Scenario 7: ew and ped together in AR2 -> one service with walk after 8 NS cycles
    run(2, 1'b0, 1'b0, 1'b0, L_AR,  1'b0, P_AR2, 7);
    run(1, 1'b1, 1'b1, 1'b1, L_AR,  1'b0, P_AR2, 7);
    run(8, 1'b1, 1'b0, 1'b0, L_NSG, 1'b0, P_NSG, 7);
    run(3, 1'b1, 1'b0, 1'b0, L_NSY, 1'b0, P_NSY, 7);
    run(2, 1'b1, 1'b0, 1'b0, L_AR,  1'b0, P_AR1, 7);
    run(6, 1'b1, 1'b0, 1'b0, L_EWG, 1'b1, P_EWG, 7);
    run(3, 1'b1, 1'b0, 1'b0, L_EWY, 1'b0, P_EWY, 7);
    run(2, 1'b1, 1'b0, 1'b0, L_AR,  1'b0, P_AR2, 7);
    run(20, 1'b1, 1'b0, 1'b0, L_NSG, 1'b0, P_NSG, 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
